// File: rtl/serial_twos_pkg.sv
// Shared types and constants for the bit-serial two's-complement negator.
package serial_twos_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 1 followed by w-1 zeros; caller truncates to its own width (w <= 64).
    function automatic logic [63:0] most_neg(input int w);
        return 64'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/twos_bit_cell.sv
// One step of the copy-until-first-1-then-invert negation rule.
module twos_bit_cell (
    input  logic b,
    input  logic seen_one,
    output logic ser_bit,
    output logic next_seen_one
);

    assign ser_bit       = b ^ seen_one;
    assign next_seen_one = seen_one | b;

endmodule

// File: rtl/serial_twos_complement.sv
// Bit-serial two's-complement negation: LSB-first serial stream plus the full
// negated word with zero / most-negative flags.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | emitting one result bit per clock, WIDTH cycles
// DONE  | full result presented until out_ready
module serial_twos_complement
    import serial_twos_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] cnt;
    logic             seen_one;
    logic             zero_reg;
    logic             ovf_reg;
    logic             cell_bit;
    logic             next_seen_one;

    twos_bit_cell u_cell (
        .b             (shift_reg[0]),
        .seen_one      (seen_one),
        .ser_bit       (cell_bit),
        .next_seen_one (next_seen_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            result_reg <= '0;
            cnt        <= '0;
            seen_one   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= a;
                        cnt       <= '0;
                        seen_one  <= 1'b0;
                        zero_reg  <= (a == '0);
                        ovf_reg   <= (a == MOST_NEG);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result fills from the MSB side so bit 0 lands in place after WIDTH shifts.
                    result_reg <= {cell_bit, result_reg[WIDTH-1:1]};
                    shift_reg  <= shift_reg >> 1;
                    seen_one   <= next_seen_one;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is asserted, before the reset edge lands.
    assign in_ready  = !rst && (state == IDLE);
    assign ser_valid = !rst && (state == SHIFT);
    assign out_valid = !rst && (state == DONE);
    assign ser_bit   = ser_valid && cell_bit;
    assign y         = rst ? '0 : result_reg;
    assign zero      = !rst && zero_reg;
    assign ovf       = !rst && ovf_reg;

endmodule

// File: tb/tb_serial_twos_complement.sv
// Scoreboard bench for serial_twos_complement and its twos_bit_cell.
module tb_serial_twos_complement;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         ser_bit;
    logic         ser_valid;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         ovf;

    logic cb, cs, cser, cnext;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] exp_y_q[$];
    logic         exp_z_q[$];
    logic         exp_o_q[$];

    always #5 clk = ~clk;

    serial_twos_complement #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ovf       (ovf)
    );

    twos_bit_cell u_cell (
        .b             (cb),
        .seen_one      (cs),
        .ser_bit       (cser),
        .next_seen_one (cnext)
    );

    task automatic push_expect(input logic [W-1:0] ey, input logic ez, input logic eo);
        exp_y_q.push_back(ey);
        exp_z_q.push_back(ez);
        exp_o_q.push_back(eo);
    endtask

    // Present a word and return after the accept edge (sampled 1 time unit later).
    task automatic send(input logic [W-1:0] val, output bit ok);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        a        = val;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        a        = W'($urandom);
        ok       = acc;
    endtask

    // Gather serial bits until out_valid; lat counts edges including the accept edge.
    task automatic collect(output logic [W-1:0] sb, output int nb, output int lat);
        sb  = '0;
        nb  = 0;
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) break;
            if (ser_valid) begin
                if (nb < W) sb[nb] = ser_bit;
                nb++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_hi got %b want 0", in_ready); else passed++;
        total++; if (y !== '0) $display("FAIL reset_y got %h want 00", y); else passed++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_lo got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if ({zero, ovf} !== 2'b00) $display("FAIL reset_flags got %b want 00", {zero, ovf}); else passed++;
    endtask

    task automatic test_bit_cell();
        logic [3:0] exp_ser;
        logic [3:0] exp_next;
        exp_ser  = 4'b0110;
        exp_next = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            {cs, cb} = 2'(i);
            #1;
            total++; if (cser !== exp_ser[i]) $display("FAIL cell_ser idx %0d got %b want %b", i, cser, exp_ser[i]); else passed++;
            total++; if (cnext !== exp_next[i]) $display("FAIL cell_next idx %0d got %b want %b", i, cnext, exp_next[i]); else passed++;
        end
    endtask

    task automatic test_negation(input string name, input logic [W-1:0] val,
                                 input logic [W-1:0] ey, input logic ez, input logic eo);
        bit ok;
        logic [W-1:0] sb, qy;
        logic qz, qo;
        int nb, lat;
        push_expect(ey, ez, eo);
        send(val, ok);
        total++; if (ok !== 1'b1) $display("FAIL %s_accept got %b want 1", name, ok); else passed++;
        collect(sb, nb, lat);
        qy = exp_y_q.pop_front();
        qz = exp_z_q.pop_front();
        qo = exp_o_q.pop_front();
        total++; if (lat !== W + 1) $display("FAIL %s_latency got %0d want %0d", name, lat, W + 1); else passed++;
        total++; if (nb !== W) $display("FAIL %s_ser_count got %0d want %0d", name, nb, W); else passed++;
        total++; if (sb !== qy) $display("FAIL %s_ser_bits got %b want %b", name, sb, qy); else passed++;
        total++; if (y !== qy) $display("FAIL %s_y got %h want %h", name, y, qy); else passed++;
        total++; if (zero !== qz) $display("FAIL %s_zero got %b want %b", name, zero, qz); else passed++;
        total++; if (ovf !== qo) $display("FAIL %s_ovf got %b want %b", name, ovf, qo); else passed++;
        release_out();
        total++; if (in_ready !== 1'b1) $display("FAIL %s_return_idle got %b want 1", name, in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [W-1:0] sb, qy;
        logic qz, qo;
        int nb, lat;
        push_expect(8'hF6, 1'b0, 1'b0);
        push_expect(8'hFF, 1'b0, 1'b0);
        send(8'h0A, ok);
        collect(sb, nb, lat);
        qy = exp_y_q.pop_front();
        qz = exp_z_q.pop_front();
        qo = exp_o_q.pop_front();
        total++; if (y !== qy) $display("FAIL bp_first_y got %h want %h", y, qy); else passed++;
        in_valid = 1'b1;
        a        = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, out_valid); else passed++;
            total++; if (y !== qy) $display("FAIL bp_hold_y cyc %0d got %h want %h", i, y, qy); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); else passed++;
        end
        release_out();
        send(8'h01, ok);
        total++; if (ok !== 1'b1) $display("FAIL bp_second_accept got %b want 1", ok); else passed++;
        collect(sb, nb, lat);
        qy = exp_y_q.pop_front();
        qz = exp_z_q.pop_front();
        qo = exp_o_q.pop_front();
        total++; if (sb !== qy) $display("FAIL bp_second_ser got %b want %b", sb, qy); else passed++;
        total++; if (y !== qy) $display("FAIL bp_second_y got %h want %h", y, qy); else passed++;
        total++; if ({zero, ovf} !== {qz, qo}) $display("FAIL bp_second_flags got %b want %b", {zero, ovf}, {qz, qo}); else passed++;
        release_out();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send(8'h0A, ok);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total++; if (ser_valid !== 1'b1) $display("FAIL mid_in_shift got %b want 1", ser_valid); else passed++;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got %b want 0", in_ready); else passed++;
        total++; if ({out_valid, ser_valid, ser_bit} !== 3'b000) $display("FAIL mid_rst_ctl got %b want 000", {out_valid, ser_valid, ser_bit}); else passed++;
        total++; if ({y, zero, ovf} !== '0) $display("FAIL mid_rst_data got %h want 0", {y, zero, ovf}); else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_after_in_ready got %b want 1", in_ready); else passed++;
        total++; if ({out_valid, ser_valid} !== 2'b00) $display("FAIL mid_after_ctl got %b want 00", {out_valid, ser_valid}); else passed++;
        test_negation("mid_new", 8'h05, 8'hFB, 1'b0, 1'b0);
    endtask

    initial begin
        cb = 1'b0;
        cs = 1'b0;
        test_reset();
        test_bit_cell();
        test_negation("basic", 8'h0A, 8'hF6, 1'b0, 1'b0);
        test_negation("negative", 8'hF6, 8'h0A, 1'b0, 1'b0);
        test_negation("zero", 8'h00, 8'h00, 1'b1, 1'b0);
        test_negation("most_neg", 8'h80, 8'h80, 1'b0, 1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
